execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port start_i, input, 1, execute-stage select strobe; operands valid while high.
REQ-004 SHALL have port ir_i, input, 32, current instruction; funct3=ir_i[14:12], ir_i[30] alt bit, rd=ir_i[11:7].
REQ-005 SHALL have port ra_i, input, 32, source operand A from decode.
REQ-006 SHALL have port rb_i, input, 32, operand B, or raw 12-bit immediate in [11:0] for I-type.
REQ-007 SHALL have port pass_i, input, 32, S-type 12-bit offset or U-type 20-bit immediate.
REQ-008 SHALL have port itype_i, input, 5, instruction class (RTYPE/ITYPE/STYPE/UTYPE).
REQ-009 SHALL have port wd_o, output, 32, register write-back data.
REQ-010 SHALL have port wd_q_o, output, 1, one-cycle write-back strobe; register file captures on its rising edge.
REQ-011 SHALL have port mem_addr_o, output, 32, store address.
REQ-012 SHALL have port mem_wdata_o, output, 32, store data.
REQ-013 SHALL have port mem_we_o, output, 1, one-cycle store strobe.
REQ-014 SHALL have ports busy_o and done_o, output, 1 each: busy = state not IDLE; done = one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM IDLE, EXEC, SHIFT, RESULT, WB; state encoding 3 bits.
REQ-016 IDLE: start_i=1 latches ir_i, ra_i, rb_i, pass_i, itype_i; next EXEC. start_i while busy_o=1 SHALL be ignored.
REQ-017 EXEC: compute result from latched operands; next RESULT, or SHIFT for serial shift with shamt!=0.
REQ-018 RESULT: wd_o/mem_addr_o/mem_wdata_o loaded and held stable; next WB.
REQ-019 WB: wd_q_o=1 (RTYPE/ITYPE/UTYPE, rd!=0), or mem_we_o=1 (STYPE); done_o=1; next IDLE.
REQ-020 Latency non-shift op: start_i sampled at edge N -> wd_q_o high cycle N+3, exactly one cycle.
REQ-021 wd_o SHALL be stable for at least one full cycle before wd_q_o rises and held until next start accepted.
REQ-022 ALU ops by funct3: 000 add (sub if RTYPE and ir[30]), 001 sll, 010 slt signed, 011 sltu, 100 xor, 101 srl (sra if ir[30]), 110 or, 111 and.
REQ-023 ITYPE operand B = sign-extended rb_i[11:0]; shift amount = operand B[4:0]; all arithmetic mod 2^32.
REQ-024 UTYPE: wd_o = pass_i[19:0] << 12.
REQ-025 STYPE: mem_addr_o = ra_i + sext(pass_i[11:0]); mem_wdata_o = rb_i; wd_q_o stays 0.
REQ-026 rd=0: no wd_q_o pulse; done_o still pulses.
REQ-027 Unrecognised itype_i: no wd_q_o/mem_we_o; done_o pulses; wd_o = 0.

Reset
REQ-028 reset SHALL force IDLE and zero wd_o, wd_q_o, mem_addr_o, mem_wdata_o, mem_we_o, busy_o, done_o and latched operands.
REQ-029 reset mid-operation (any state) SHALL abort; no strobe issued on or after reset edge.
REQ-030 reset has priority over start_i in same cycle.

Configuration
REQ-031 Macro EXEC_SERIAL_SHIFT_EN defined: shifts iterate one bit per cycle in SHIFT (shamt cycles, shamt=0 skips SHIFT); undefined: single-cycle barrel shift in EXEC, REQ-020 latency for all ops.

Structure
REQ-032 Shared package SHALL hold itype codes, opcode constants, funct3 ALU codes, FSM state constants.
REQ-033 One sub-module exec_shifter (left/logical-right/arith-right, serial or barrel per macro).

Verification
REQ-034 add: ra=5, rb=7, funct3=000, rd=3 -> wd_o=12 stable before wd_q_o, wd_q_o one cycle at N+3.
REQ-035 sub/sra: ra=0x80000000, rb=4, ir[30]=1, funct3=101 -> wd_o=0xF8000000; with macro, wd_q_o at N+7.
REQ-036 addi: ra=1, rb_i[11:0]=0xFFF -> wd_o=0; rd=0 variant -> no wd_q_o, done_o pulses.
REQ-037 store: ra=0x100, pass=0xFFC, rb=0xDEADBEEF -> mem_addr_o=0xFC, mem_wdata_o=0xDEADBEEF, mem_we_o one cycle, wd_q_o=0.
REQ-038 lui pass=0xABCDE -> wd_o=0xABCDE000; second start_i during busy ignored.
REQ-039 reset asserted in RESULT -> IDLE next cycle, all outputs 0, no wd_q_o.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// ----------------------------------------------------------------------------
// execute_stage_pkg
// Shared definitions for the execute stage:
//   - instruction class codes carried on itype_i
//   - RISC-V major opcode constants used to build instruction words
//   - funct3 ALU operation codes
//   - FSM state encoding (3 bits)
//   - sext12 helper for 12-bit immediates
// ----------------------------------------------------------------------------
package execute_stage_pkg;

  localparam int XLEN = 32;

  // Instruction classes, one-hot so an unrecognised code is easy to spot
  localparam logic [4:0] ITYPE_R = 5'b00001;
  localparam logic [4:0] ITYPE_I = 5'b00010;
  localparam logic [4:0] ITYPE_S = 5'b00100;
  localparam logic [4:0] ITYPE_U = 5'b01000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_RESULT = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/exec_shifter.sv
// ----------------------------------------------------------------------------
// exec_shifter
// Left / logical-right / arithmetic-right shifter for the execute stage.
// Build option: EXEC_SERIAL_SHIFT_EN
//   undefined : combinational barrel shift of data_i by shamt_i
//   defined   : load_i captures data/amount/direction, each step_i shifts one
//               bit; result_o shows the value after the current step and
//               last_o flags the final step
// Ports:
//   clk, reset        (serial build only) clock, synchronous active-high reset
//   load_i, step_i    (serial build only) capture operands / advance one bit
//   data_i [31:0]     value to shift
//   shamt_i [4:0]     shift amount
//   left_i            1 = shift left, 0 = shift right
//   arith_i           right shifts replicate the sign bit when set
//   result_o [31:0]   shifted value
//   last_o            (serial build only) current step is the final one
// ----------------------------------------------------------------------------
module exec_shifter (
`ifdef EXEC_SERIAL_SHIFT_EN
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        step_i,
  output logic        last_o,
`endif
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  input  logic        left_i,
  input  logic        arith_i,
  output logic [31:0] result_o
);

`ifdef EXEC_SERIAL_SHIFT_EN
  logic [31:0] data_q;
  logic [4:0]  cnt_q;
  logic        left_q;
  logic        arith_q;

  // One-bit step of the held value; the caller samples this on the last step
  always_comb begin
    if (left_q) result_o = {data_q[30:0], 1'b0};
    else        result_o = {arith_q & data_q[31], data_q[31:1]};
  end

  assign last_o = (cnt_q == 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      cnt_q   <= shamt_i;
      left_q  <= left_i;
      arith_q <= arith_i;
    end else if (step_i) begin
      data_q <= result_o;
      cnt_q  <= cnt_q - 5'd1;
    end
  end
`else
  always_comb begin
    if (left_i)       result_o = data_i << shamt_i;
    else if (arith_i) result_o = $unsigned($signed(data_i) >>> shamt_i);
    else              result_o = data_i >> shamt_i;
  end
`endif

endmodule

// File: rtl/execute_stage.sv
// ----------------------------------------------------------------------------
// execute_stage
// Multi-cycle execute stage: IDLE -> EXEC -> [SHIFT] -> RESULT -> WB -> IDLE.
// Operands are latched when start_i is seen in IDLE; results are registered
// on entry to RESULT and the write-back / store strobe is high for the WB
// cycle only, so wd_o is stable for a full cycle before wd_q_o rises.
// Build option: EXEC_SERIAL_SHIFT_EN selects a one-bit-per-cycle shifter
// (SHIFT state, shamt cycles) instead of a single-cycle barrel shift.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start_i           start strobe (ignored while busy_o)
//   ir_i [31:0]       instruction (funct3 [14:12], alt [30], rd [11:7])
//   ra_i, rb_i        operands (rb_i[11:0] is the I-type immediate)
//   pass_i [31:0]     S-type offset [11:0] or U-type immediate [19:0]
//   itype_i [4:0]     instruction class
//   wd_o, wd_q_o      write-back data and one-cycle write strobe
//   mem_addr_o, mem_wdata_o, mem_we_o   store address/data/strobe
//   busy_o, done_o    not-idle flag and one-cycle completion pulse
// ----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] ir_i,
  input  logic [31:0] ra_i,
  input  logic [31:0] rb_i,
  input  logic [31:0] pass_i,
  input  logic [4:0]  itype_i,
  output logic [31:0] wd_o,
  output logic        wd_q_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        done_o
);

  state_e      state_q, state_d;
  logic [2:0]  funct3_q;
  logic        alt_q;
  logic [4:0]  rd_q;
  logic [4:0]  itype_q;
  logic [31:0] ra_q, rb_q;
  logic [19:0] pass_q;
  logic [31:0] wd_q, mem_addr_q, mem_wdata_q;
  logic        wd_strobe_q, wd_strobe_d;
  logic        mem_we_q, mem_we_d;
  logic        done_q, done_d;
  logic        capture, load_res;
  logic        is_alu, is_shift, wb_en;
  logic [31:0] opb, sh_result, shift_val, alu_res, result;
  logic        unused_bits;

  // Instruction fields outside funct3/alt/rd and the upper pass_i bits are not needed
  assign unused_bits = ^{ir_i[31], ir_i[29:15], ir_i[6:0], pass_i[31:20]};

  always_comb begin
    is_alu   = (itype_q == ITYPE_R) || (itype_q == ITYPE_I);
    opb      = (itype_q == ITYPE_I) ? sext12(rb_q[11:0]) : rb_q;
    is_shift = is_alu && ((funct3_q == F3_SLL) || (funct3_q == F3_SRL));
    wb_en    = (is_alu || (itype_q == ITYPE_U)) && (rd_q != 5'd0);
  end

`ifdef EXEC_SERIAL_SHIFT_EN
  logic shift_load, shift_step, sh_last;

  exec_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load_i   (shift_load),
    .step_i   (shift_step),
    .last_o   (sh_last),
    .data_i   (ra_q),
    .shamt_i  (opb[4:0]),
    .left_i   (funct3_q == F3_SLL),
    .arith_i  (alt_q),
    .result_o (sh_result)
  );

  // A zero-amount shift never enters SHIFT, so EXEC passes operand A through
  assign shift_val = (state_q == ST_EXEC) ? ra_q : sh_result;
`else
  exec_shifter u_shifter (
    .data_i   (ra_q),
    .shamt_i  (opb[4:0]),
    .left_i   (funct3_q == F3_SLL),
    .arith_i  (alt_q),
    .result_o (sh_result)
  );

  assign shift_val = sh_result;
`endif

  // ALU and result select; sub only for R-type, unknown classes yield zero
  always_comb begin
    alu_res = '0;
    case (funct3_q)
      F3_ADD:         alu_res = (itype_q == ITYPE_R && alt_q) ? ra_q - opb : ra_q + opb;
      F3_SLL, F3_SRL: alu_res = shift_val;
      F3_SLT:         alu_res = {31'd0, $signed(ra_q) < $signed(opb)};
      F3_SLTU:        alu_res = {31'd0, ra_q < opb};
      F3_XOR:         alu_res = ra_q ^ opb;
      F3_OR:          alu_res = ra_q | opb;
      F3_AND:         alu_res = ra_q & opb;
      default:        alu_res = '0;
    endcase
    if (is_alu)                  result = alu_res;
    else if (itype_q == ITYPE_U) result = {pass_q, 12'd0};
    else                         result = '0;
  end

  // Next-state logic; strobes are computed one state early and registered
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    load_res    = 1'b0;
    wd_strobe_d = 1'b0;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;
`ifdef EXEC_SERIAL_SHIFT_EN
    shift_load  = 1'b0;
    shift_step  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          capture = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
`ifdef EXEC_SERIAL_SHIFT_EN
        if (is_shift && (opb[4:0] != 5'd0)) begin
          shift_load = 1'b1;
          state_d    = ST_SHIFT;
        end else begin
          load_res = 1'b1;
          state_d  = ST_RESULT;
        end
`else
        load_res = 1'b1;
        state_d  = ST_RESULT;
`endif
      end
      ST_SHIFT: begin
`ifdef EXEC_SERIAL_SHIFT_EN
        shift_step = 1'b1;
        if (sh_last) begin
          load_res = 1'b1;
          state_d  = ST_RESULT;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_RESULT: begin
        wd_strobe_d = wb_en;
        mem_we_d    = (itype_q == ITYPE_S);
        done_d      = 1'b1;
        state_d     = ST_WB;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      funct3_q    <= '0;
      alt_q       <= 1'b0;
      rd_q        <= '0;
      itype_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      pass_q      <= '0;
      wd_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wd_strobe_q <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_strobe_q <= wd_strobe_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      if (capture) begin
        funct3_q <= ir_i[14:12];
        alt_q    <= ir_i[30];
        rd_q     <= ir_i[11:7];
        itype_q  <= itype_i;
        ra_q     <= ra_i;
        rb_q     <= rb_i;
        pass_q   <= pass_i[19:0];
      end
      // Stores leave wd_o untouched; everything else leaves the memory port untouched
      if (load_res) begin
        if (itype_q == ITYPE_S) begin
          mem_addr_q  <= ra_q + sext12(pass_q[11:0]);
          mem_wdata_q <= rb_q;
        end else begin
          wd_q <= result;
        end
      end
    end
  end

  assign wd_o        = wd_q;
  assign wd_q_o      = wd_strobe_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_execute_stage.sv
// ----------------------------------------------------------------------------
// tb_execute_stage
// Self-checking bench for execute_stage: directed operations, a run of random
// operations against an arithmetic reference model, and reset abort.
// Honours EXEC_SERIAL_SHIFT_EN when computing the expected latency.
// ----------------------------------------------------------------------------
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [31:0] ir_i, ra_i, rb_i, pass_i;
  logic [4:0]  itype_i;
  logic [31:0] wd_o, mem_addr_o, mem_wdata_o;
  logic        wd_q_o, mem_we_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .ir_i        (ir_i),
    .ra_i        (ra_i),
    .rb_i        (rb_i),
    .pass_i      (pass_i),
    .itype_i     (itype_i),
    .wd_o        (wd_o),
    .wd_q_o      (wd_q_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkIr(input logic [2:0] f3, input logic alt,
                                       input logic [4:0] rd, input logic [6:0] opc);
    return {1'b0, alt, 10'd0, 5'd0, f3, rd, opc};
  endfunction

  // Reference model straight from the instruction semantics
  task automatic modelOp(input logic [31:0] ir, input logic [31:0] ra, input logic [31:0] rb,
                         input logic [31:0] pass, input logic [4:0] it,
                         output logic [31:0] expWd, output logic [31:0] expAddr,
                         output logic [31:0] expData, output bit expWdq, output bit expWe,
                         output bit checkWd, output int lat);
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, sh;
    logic [31:0] b;
    bit          alu;
    f3  = ir[14:12];
    alt = ir[30];
    rd  = ir[11:7];
    alu = (it == ITYPE_R) || (it == ITYPE_I);
    b   = (it == ITYPE_I) ? {{20{rb[11]}}, rb[11:0]} : rb;
    sh  = b[4:0];
    expWd = 32'd0; expAddr = 32'd0; expData = 32'd0;
    expWdq = 0; expWe = 0; checkWd = 1; lat = 3;
    if (alu) begin
      case (f3)
        3'd0: expWd = (it == ITYPE_R && alt) ? ra - b : ra + b;
        3'd1: expWd = ra << sh;
        3'd2: expWd = ($signed(ra) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: expWd = (ra < b) ? 32'd1 : 32'd0;
        3'd4: expWd = ra ^ b;
        3'd5: expWd = alt ? $unsigned($signed(ra) >>> sh) : ra >> sh;
        3'd6: expWd = ra | b;
        default: expWd = ra & b;
      endcase
      expWdq = (rd != 5'd0);
`ifdef EXEC_SERIAL_SHIFT_EN
      if ((f3 == 3'd1 || f3 == 3'd5) && sh != 5'd0) lat = 3 + int'(sh);
`endif
    end else if (it == ITYPE_U) begin
      expWd  = {pass[19:0], 12'h000};
      expWdq = (rd != 5'd0);
    end else if (it == ITYPE_S) begin
      expAddr = ra + {{20{pass[11]}}, pass[11:0]};
      expData = rb;
      expWe   = 1;
      checkWd = 0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] ra, input logic [31:0] rb,
                               input logic [31:0] pass, input logic [4:0] it);
    @(negedge clk);
    ir_i = ir; ra_i = ra; rb_i = rb; pass_i = pass; itype_i = it;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    ir_i = $urandom; ra_i = $urandom; rb_i = $urandom; pass_i = $urandom; itype_i = 5'($urandom);
  endtask

  // Issue one operation and observe it until one cycle after done_o
  task automatic runOp(input string tag, input logic [31:0] ir, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [31:0] pass, input logic [4:0] it,
                       input bit poke);
    logic [31:0] expWd, expAddr, expData, prevWd, wdAtStrobe, wdBefore, wdAtDone, addrSeen, dataSeen;
    bit expWdq, expWe, checkWd;
    int lat, wdqCnt, wdqAt, weCnt, weAt, doneCnt, doneAt;
    logic busyAfter;
    modelOp(ir, ra, rb, pass, it, expWd, expAddr, expData, expWdq, expWe, checkWd, lat);
    wdqCnt = 0; wdqAt = 0; weCnt = 0; weAt = 0; doneCnt = 0; doneAt = 0;
    wdAtStrobe = '0; wdBefore = '0; wdAtDone = '0; addrSeen = '0; dataSeen = '0;
    busyAfter = 1'bx;
    applyStimulus(ir, ra, rb, pass, it);
    prevWd = wd_o;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (poke && k == 2) begin
        start_i = 1'b1; ir_i = mkIr(3'd0, 1'b0, 5'd9, OPC_LUI);
        pass_i = 32'h12345; itype_i = ITYPE_U;
      end else begin
        start_i = 1'b0;
      end
      if (wd_q_o) begin wdqCnt++; wdqAt = k; wdAtStrobe = wd_o; wdBefore = prevWd; end
      if (mem_we_o) begin weCnt++; weAt = k; addrSeen = mem_addr_o; dataSeen = mem_wdata_o; end
      if (done_o) begin doneCnt++; doneAt = k; wdAtDone = wd_o; end
      prevWd = wd_o;
      if (doneAt != 0 && k == doneAt + 1) begin
        busyAfter = busy_o;
        break;
      end
    end
    checkOutput({tag, "_done_cnt"}, doneCnt, 1);
    checkOutput({tag, "_done_at"}, doneAt, lat);
    checkOutput({tag, "_busy_after"}, {31'd0, busyAfter}, 0);
    if (checkWd) checkOutput({tag, "_wd"}, wdAtDone, expWd);
    if (expWdq) begin
      checkOutput({tag, "_wdq_cnt"}, wdqCnt, 1);
      checkOutput({tag, "_wdq_at"}, wdqAt, lat);
      checkOutput({tag, "_wd_at_strobe"}, wdAtStrobe, expWd);
      checkOutput({tag, "_wd_before"}, wdBefore, expWd);
    end else begin
      checkOutput({tag, "_no_wdq"}, wdqCnt, 0);
    end
    if (expWe) begin
      checkOutput({tag, "_we_cnt"}, weCnt, 1);
      checkOutput({tag, "_we_at"}, weAt, lat);
      checkOutput({tag, "_addr"}, addrSeen, expAddr);
      checkOutput({tag, "_wdata"}, dataSeen, expData);
    end else begin
      checkOutput({tag, "_no_we"}, weCnt, 0);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_wd"}, wd_o, 0);
    checkOutput({tag, "_wdq"}, {31'd0, wd_q_o}, 0);
    checkOutput({tag, "_addr"}, mem_addr_o, 0);
    checkOutput({tag, "_wdata"}, mem_wdata_o, 0);
    checkOutput({tag, "_we"}, {31'd0, mem_we_o}, 0);
    checkOutput({tag, "_busy"}, {31'd0, busy_o}, 0);
    checkOutput({tag, "_done"}, {31'd0, done_o}, 0);
  endtask

  initial begin
    logic [4:0] classes [5];
    logic [31:0] rir;
    logic [4:0]  rit;
    int strobes;
    classes[0] = ITYPE_R; classes[1] = ITYPE_I; classes[2] = ITYPE_S;
    classes[3] = ITYPE_U; classes[4] = 5'b10000;

    reset = 1'b1; start_i = 1'b0;
    ir_i = '0; ra_i = '0; rb_i = '0; pass_i = '0; itype_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset_state");
    reset = 1'b0;

    runOp("add",    mkIr(3'd0, 1'b0, 5'd3, OPC_OP),     32'd5,         32'd7,         32'd0,     ITYPE_R, 0);
    runOp("sra",    mkIr(3'd5, 1'b1, 5'd5, OPC_OP),     32'h8000_0000, 32'd4,         32'd0,     ITYPE_R, 0);
    runOp("addi",   mkIr(3'd0, 1'b0, 5'd4, OPC_OP_IMM), 32'd1,         32'h0000_0FFF, 32'd0,     ITYPE_I, 0);
    runOp("addi_x0",mkIr(3'd0, 1'b0, 5'd0, OPC_OP_IMM), 32'd1,         32'h0000_0FFF, 32'd0,     ITYPE_I, 0);
    runOp("store",  mkIr(3'd2, 1'b0, 5'd0, OPC_STORE),  32'h0000_0100, 32'hDEAD_BEEF, 32'hFFC,   ITYPE_S, 0);
    runOp("lui",    mkIr(3'd0, 1'b0, 5'd7, OPC_LUI),    32'd0,         32'd0,         32'hABCDE, ITYPE_U, 1);
    runOp("unknown",mkIr(3'd0, 1'b0, 5'd9, OPC_OP),     32'd3,         32'd4,         32'd0,     5'b10000, 0);

    for (int n = 0; n < 24; n++) begin
      rit = classes[$urandom_range(0, 4)];
      rir = mkIr(3'($urandom_range(0, 7)), 1'($urandom), 5'($urandom), OPC_OP);
      runOp($sformatf("rand%0d", n), rir, $urandom, $urandom, $urandom, rit, 0);
    end

    // Reset while the operation sits in RESULT
    applyStimulus(mkIr(3'd0, 1'b0, 5'd2, OPC_OP), 32'd10, 32'd20, 32'd0, ITYPE_R);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_result_busy", {31'd0, busy_o}, 1);
    checkOutput("rst_in_result_wd", wd_o, 32'd30);
    reset = 1'b1;
    @(negedge clk);
    checkIdleZero("rst_abort");
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wd_q_o || done_o || mem_we_o || busy_o) strobes++;
    end
    checkOutput("rst_no_strobe_after", strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
